// File: rtl/retire_trace_buf_if.sv
// Retire-event producer and trace-record consumer signals of retire_trace_buf.
// The slave modport is the buffer's view; master is the pipeline/consumer side.
interface retire_trace_buf_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
);
  logic              ret_valid;
  logic              ret_ready;
  logic [DATA_W-1:0] ret_pc;
  logic              ret_regwrite;
  logic [REG_W-1:0]  ret_wreg;
  logic [DATA_W-1:0] ret_wdata;
  logic              ret_memread;
  logic              ret_memwrite;
  logic [DATA_W-1:0] ret_memaddr;
  logic [DATA_W-1:0] ret_memdata;
  logic              ret_halt;

  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_kind;
  logic [CNT_W-1:0]  out_inum;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_wdata;
  logic [DATA_W-1:0] out_addr;
  logic [DATA_W-1:0] out_mdata;
  logic [REG_W-1:0]  out_reg;

  modport master (
    output ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata, ret_memread,
           ret_memwrite, ret_memaddr, ret_memdata, ret_halt, out_ready,
    input  ret_ready, out_valid, out_kind, out_inum, out_pc, out_wdata,
           out_addr, out_mdata, out_reg
  );

  modport slave (
    input  ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata, ret_memread,
           ret_memwrite, ret_memaddr, ret_memdata, ret_halt, out_ready,
    output ret_ready, out_valid, out_kind, out_inum, out_pc, out_wdata,
           out_addr, out_mdata, out_reg
  );
endinterface

// File: rtl/retire_trace_buf.sv
// Retirement-trace capture: classifies retire events, tags them with an
// instruction number, queues them in a FIFO and handles the post-halt drain.
module retire_trace_buf #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  retire_trace_buf_if.slave bus,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic             overflow,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [2:0]        kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
    logic [REG_W-1:0]  rd;
  } rec_t;

  state_t           state_q;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cycle_q, inst_q;
  logic             overflow_q;
  logic             done_q;
  rec_t             mem_q [DEPTH];
  rec_t             rec_d;
  rec_t             head;

  logic full, empty, push, pop, drop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign bus.ret_ready = !full && (state_q != DONE);
  assign push = bus.ret_valid && bus.ret_ready && (state_q == RUN);
  assign drop = bus.ret_valid && !bus.ret_ready && (state_q == RUN);
  assign pop  = !empty && bus.out_ready;

  // Priority classification; fields irrelevant to the kind are zeroed here.
  always_comb begin
    rec_d      = '0;
    rec_d.inum = inst_q;
    rec_d.pc   = bus.ret_pc;
    if (bus.ret_halt) begin
      rec_d.kind = 3'd5;
    end else if (bus.ret_regwrite && bus.ret_memwrite) begin
      rec_d.kind  = 3'd4;
      rec_d.rd    = bus.ret_wreg;
      rec_d.wdata = bus.ret_wdata;
      rec_d.addr  = bus.ret_memaddr;
      rec_d.mdata = bus.ret_memdata;
    end else if (bus.ret_memwrite) begin
      rec_d.kind  = 3'd3;
      rec_d.addr  = bus.ret_memaddr;
      rec_d.mdata = bus.ret_memdata;
    end else if (bus.ret_regwrite && bus.ret_memread) begin
      rec_d.kind  = 3'd2;
      rec_d.rd    = bus.ret_wreg;
      rec_d.wdata = bus.ret_wdata;
      rec_d.addr  = bus.ret_memaddr;
    end else if (bus.ret_regwrite) begin
      rec_d.kind  = 3'd1;
      rec_d.rd    = bus.ret_wreg;
      rec_d.wdata = bus.ret_wdata;
    end else begin
      rec_d.kind = 3'd0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cycle_q    <= '0;
      inst_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        inst_q   <= inst_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
      if (state_q != DONE) cycle_q <= cycle_q + 1'b1;
      case (state_q)
        RUN: begin
          if (push && bus.ret_halt) state_q <= DRAIN;
        end
        DRAIN: begin
          if (empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign bus.out_valid = !empty;
  assign bus.out_kind  = head.kind;
  assign bus.out_inum  = head.inum;
  assign bus.out_pc    = head.pc;
  assign bus.out_wdata = head.wdata;
  assign bus.out_addr  = head.addr;
  assign bus.out_mdata = head.mdata;
  assign bus.out_reg   = head.rd;

  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed self-checking bench for retire_trace_buf: one task per scenario,
// expected values hand-computed from the classification and FIFO rules.
module tb_retire_trace_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cycle_count, inst_count;
  logic        overflow, done;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] saved_cycles;

  retire_trace_buf_if #(.DATA_W(16), .REG_W(3), .CNT_W(32)) bus ();

  retire_trace_buf #(.DATA_W(16), .REG_W(3), .DEPTH(8), .CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .cycle_count(cycle_count),
    .inst_count(inst_count),
    .overflow(overflow),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic v, input logic [15:0] pc, input logic rw,
                          input logic [2:0] wr, input logic [15:0] wd,
                          input logic mr, input logic mw, input logic [15:0] a,
                          input logic [15:0] md, input logic h);
    bus.ret_valid    = v;
    bus.ret_pc       = pc;
    bus.ret_regwrite = rw;
    bus.ret_wreg     = wr;
    bus.ret_wdata    = wd;
    bus.ret_memread  = mr;
    bus.ret_memwrite = mw;
    bus.ret_memaddr  = a;
    bus.ret_memdata  = md;
    bus.ret_halt     = h;
  endtask

  task automatic idle();
    drive_ev(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", bus.out_valid); end
    checks++; if (bus.ret_ready !== 1'b1) begin errors++; $display("FAIL reset_ret_ready got %0d exp 1", bus.ret_ready); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", cycle_count); end
    checks++; if (inst_count !== 32'd0) begin errors++; $display("FAIL reset_inst got %0d exp 0", inst_count); end
    checks++; if ({overflow, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, done}); end
    checks++; if (bus.out_pc !== 16'h0) begin errors++; $display("FAIL reset_out_pc got %h exp 0000", bus.out_pc); end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    do_reset();
    drive_ev(1'b1, 16'h0002, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0055, 16'h0066, 1'b0);
    tick();
    idle();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %0d exp 1", bus.out_valid); end
    checks++; if (bus.out_kind !== 3'd1) begin errors++; $display("FAIL alu_kind got %0d exp 1", bus.out_kind); end
    checks++; if (bus.out_inum !== 32'd0) begin errors++; $display("FAIL alu_inum got %0d exp 0", bus.out_inum); end
    checks++; if ({bus.out_reg, bus.out_wdata, bus.out_pc} !== {3'd3, 16'h1234, 16'h0002}) begin errors++; $display("FAIL alu_fields got reg=%0d wdata=%h pc=%h exp 3 1234 0002", bus.out_reg, bus.out_wdata, bus.out_pc); end
    checks++; if ({bus.out_addr, bus.out_mdata} !== 32'h0) begin errors++; $display("FAIL alu_zeroed got addr=%h mdata=%h exp 0", bus.out_addr, bus.out_mdata); end
    checks++; if (inst_count !== 32'd1) begin errors++; $display("FAIL alu_inst_count got %0d exp 1", inst_count); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL alu_popped got %0d exp 0", bus.out_valid); end
    $display("test_alu done");
  endtask

  task automatic test_kinds();
    do_reset();
    // load, stu, store, memread-without-regwrite
    drive_ev(1'b1, 16'h0010, 1'b1, 3'd5, 16'h00AA, 1'b1, 1'b0, 16'h0040, 16'h5555, 1'b0); tick();
    drive_ev(1'b1, 16'h0012, 1'b1, 3'd2, 16'h0077, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0); tick();
    drive_ev(1'b1, 16'h0014, 1'b0, 3'd6, 16'h9999, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0); tick();
    drive_ev(1'b1, 16'h0016, 1'b0, 3'd4, 16'h8888, 1'b1, 1'b0, 16'h0030, 16'h2222, 1'b0); tick();
    idle();
    checks++; if ({bus.out_kind, bus.out_inum} !== {3'd2, 32'd0}) begin errors++; $display("FAIL load_kind_inum got %0d/%0d exp 2/0", bus.out_kind, bus.out_inum); end
    checks++; if ({bus.out_reg, bus.out_wdata, bus.out_addr, bus.out_mdata} !== {3'd5, 16'h00AA, 16'h0040, 16'h0000}) begin errors++; $display("FAIL load_fields got reg=%0d wd=%h a=%h md=%h exp 5 00aa 0040 0000", bus.out_reg, bus.out_wdata, bus.out_addr, bus.out_mdata); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    checks++; if ({bus.out_kind, bus.out_inum} !== {3'd4, 32'd1}) begin errors++; $display("FAIL stu_kind_inum got %0d/%0d exp 4/1", bus.out_kind, bus.out_inum); end
    checks++; if ({bus.out_reg, bus.out_wdata, bus.out_addr, bus.out_mdata} !== {3'd2, 16'h0077, 16'h0010, 16'hBEEF}) begin errors++; $display("FAIL stu_fields got reg=%0d wd=%h a=%h md=%h exp 2 0077 0010 beef", bus.out_reg, bus.out_wdata, bus.out_addr, bus.out_mdata); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    checks++; if ({bus.out_kind, bus.out_reg, bus.out_wdata, bus.out_addr, bus.out_mdata} !== {3'd3, 3'd0, 16'h0000, 16'h0020, 16'h1111}) begin errors++; $display("FAIL store_fields got k=%0d reg=%0d wd=%h a=%h md=%h exp 3 0 0000 0020 1111", bus.out_kind, bus.out_reg, bus.out_wdata, bus.out_addr, bus.out_mdata); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    checks++; if ({bus.out_kind, bus.out_pc, bus.out_addr, bus.out_wdata} !== {3'd0, 16'h0016, 16'h0000, 16'h0000}) begin errors++; $display("FAIL memread_nop got k=%0d pc=%h a=%h wd=%h exp 0 0016 0000 0000", bus.out_kind, bus.out_pc, bus.out_addr, bus.out_wdata); end
    $display("test_kinds done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_ev(1'b1, 16'(i), 1'b1, 3'd1, 16'(i * 17), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      checks++; if (bus.ret_ready !== (i < 8)) begin errors++; $display("FAIL ovf_ready_%0d got %0d exp %0d", i, bus.ret_ready, (i < 8)); end
      tick();
      if (i == 7) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0d exp 0", overflow); end
      end
    end
    idle();
    checks++; if ({overflow, bus.ret_ready} !== 2'b10) begin errors++; $display("FAIL ovf_flags got ovf=%0d ready=%0d exp 1 0", overflow, bus.ret_ready); end
    checks++; if (inst_count !== 32'd8) begin errors++; $display("FAIL ovf_inst got %0d exp 8", inst_count); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if ({bus.out_valid, bus.out_inum, bus.out_pc} !== {1'b1, 32'(k), 16'(k)}) begin errors++; $display("FAIL ovf_pop_%0d got v=%0d inum=%0d pc=%h exp 1 %0d %h", k, bus.out_valid, bus.out_inum, bus.out_pc, k, k); end
      tick();
    end
    checks++; if ({bus.out_valid, overflow} !== 2'b01) begin errors++; $display("FAIL ovf_after got v=%0d ovf=%0d exp 0 1", bus.out_valid, overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    drive_ev(1'b1, 16'h000A, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); tick();
    checks++; if ({bus.out_valid, bus.out_pc, bus.out_inum} !== {1'b1, 16'h000A, 32'd0}) begin errors++; $display("FAIL b2b_first got v=%0d pc=%h inum=%0d exp 1 000a 0", bus.out_valid, bus.out_pc, bus.out_inum); end
    drive_ev(1'b1, 16'h000B, 1'b1, 3'd2, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); tick();
    checks++; if ({bus.out_valid, bus.out_pc, bus.out_inum} !== {1'b1, 16'h000B, 32'd1}) begin errors++; $display("FAIL b2b_replace got v=%0d pc=%h inum=%0d exp 1 000b 1", bus.out_valid, bus.out_pc, bus.out_inum); end
    idle(); tick();
    checks++; if ({bus.out_valid, inst_count} !== {1'b0, 32'd2}) begin errors++; $display("FAIL b2b_end got v=%0d inst=%0d exp 0 2", bus.out_valid, inst_count); end
    $display("test_back_to_back done");
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_ev(i % 2 == 0, 16'(i), 1'b1, 3'd1, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    checks++; if (inst_count !== 32'd2) begin errors++; $display("FAIL bub_inst got %0d exp 2", inst_count); end
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL bub_cycles got %0d exp 4", cycle_count); end
    checks++; if ({bus.out_inum, bus.out_pc} !== {32'd0, 16'd0}) begin errors++; $display("FAIL bub_head0 got inum=%0d pc=%h exp 0 0000", bus.out_inum, bus.out_pc); end
    bus.out_ready = 1'b1; tick();
    checks++; if ({bus.out_inum, bus.out_pc} !== {32'd1, 16'd2}) begin errors++; $display("FAIL bub_head1 got inum=%0d pc=%h exp 1 0002", bus.out_inum, bus.out_pc); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bub_empty got %0d exp 0", bus.out_valid); end
    $display("test_bubbles done");
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_ev(1'b1, 16'(i), 1'b1, 3'd1, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); tick();
    end
    drive_ev(1'b1, 16'h0100, 1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1); tick();
    drive_ev(1'b1, 16'h0200, 1'b1, 3'd1, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick(); tick();
    checks++; if ({inst_count, overflow, done, bus.ret_ready} !== {32'd4, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL halt_drain got inst=%0d ovf=%0d done=%0d ready=%0d exp 4 0 0 1", inst_count, overflow, done, bus.ret_ready); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({bus.out_kind, bus.out_inum} !== {(k == 3) ? 3'd5 : 3'd1, 32'(k)}) begin errors++; $display("FAIL halt_pop_%0d got kind=%0d inum=%0d exp %0d %0d", k, bus.out_kind, bus.out_inum, (k == 3) ? 5 : 1, k); end
      if (k == 3) begin
        checks++; if ({bus.out_pc, bus.out_wdata, bus.out_reg} !== {16'h0100, 16'h0000, 3'd0}) begin errors++; $display("FAIL halt_fields got pc=%h wd=%h reg=%0d exp 0100 0000 0", bus.out_pc, bus.out_wdata, bus.out_reg); end
      end
      tick();
    end
    checks++; if ({bus.out_valid, done} !== 2'b00) begin errors++; $display("FAIL halt_pre_done got v=%0d done=%0d exp 0 0", bus.out_valid, done); end
    tick();
    checks++; if ({done, bus.ret_ready} !== 2'b10) begin errors++; $display("FAIL halt_done got done=%0d ready=%0d exp 1 0", done, bus.ret_ready); end
    saved_cycles = cycle_count;
    tick(); tick(); tick();
    checks++; if ({cycle_count, inst_count, done} !== {saved_cycles, 32'd4, 1'b1}) begin errors++; $display("FAIL halt_frozen got cyc=%0d inst=%0d done=%0d exp %0d 4 1", cycle_count, inst_count, done, saved_cycles); end
    idle();
    $display("test_halt done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_ev(1'b1, 16'(i), 1'b1, 3'd1, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); tick();
    end
    idle();
    checks++; if ({bus.out_valid, inst_count} !== {1'b1, 32'd5}) begin errors++; $display("FAIL mid_pre got v=%0d inst=%0d exp 1 5", bus.out_valid, inst_count); end
    do_reset();
    checks++; if ({bus.out_valid, overflow, done, bus.ret_ready} !== 4'b0001) begin errors++; $display("FAIL mid_flags got v=%0d ovf=%0d done=%0d ready=%0d exp 0 0 0 1", bus.out_valid, overflow, done, bus.ret_ready); end
    checks++; if ({cycle_count, inst_count} !== 64'd0) begin errors++; $display("FAIL mid_counts got cyc=%0d inst=%0d exp 0 0", cycle_count, inst_count); end
    $display("test_reset_mid done");
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b0;
    test_reset();
    test_alu();
    test_kinds();
    test_overflow();
    test_back_to_back();
    test_bubbles();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
